// File: rtl/systolic_mem_bridge_if.sv
// Host request/acknowledge bus of systolic_mem_bridge.
// master = host or loader, slave = memory bridge.
interface systolic_mem_bridge_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [WIDTH-1:0]  host_wdata;
  logic [WIDTH-1:0]  host_rdata;
  logic              host_ack;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack
  );
endinterface

// File: rtl/systolic_mem_bridge.sv
// Data memory and launch sequencer for the systolic controller.
// Optional RUN watchdog: define SYSTOLIC_MEM_WATCHDOG_EN.
module systolic_mem_bridge #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_mem_bridge_if.slave     hbus,
  input  logic                     host_start,
  input  logic [ADDR_W-1:0]        cfg_addr_A,
  input  logic [ADDR_W-1:0]        cfg_addr_B,
  input  logic [ADDR_W-1:0]        cfg_addr_C,
  input  logic [3:0]               cfg_n,
  input  logic [ADDR_W-1:0]        acc_addr,
  input  logic                     acc_we,
  input  logic signed [WIDTH-1:0]  acc_wdata,
  output logic signed [WIDTH-1:0]  acc_rdata,
  output logic                     new_data,
  output logic [ADDR_W-1:0]        addr_A,
  output logic [ADDR_W-1:0]        addr_B,
  output logic [ADDR_W-1:0]        addr_C,
  output logic [3:0]               n,
  output logic                     busy,
  output logic                     done,
  output logic                     addr_err,
  output logic                     timeout_err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [3:0]        n_q, n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              start_ok, host_ok, acc_ok;
  logic              mem_we, tmo_hit;
  logic [IW-1:0]     host_idx, acc_idx, mem_idx;
  logic [WIDTH-1:0]  mem_wd;

  assign start_ok = host_start && (cfg_n != 4'd0) && (cfg_n <= 4'd4);
  assign host_ok  = 32'(hbus.host_addr) < DEPTH;
  assign acc_ok   = 32'(acc_addr) < DEPTH;
  assign host_idx = hbus.host_addr[IW-1:0];
  assign acc_idx  = acc_addr[IW-1:0];
  assign acc_rdata = acc_ok ? mem[acc_idx] : '0;

`ifdef SYSTOLIC_MEM_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  always_comb begin
    cnt_d = '0;
    if (state_q == RUN) cnt_d = cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == RUN) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_q | tmo_hit;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    n_d     = n_q;
    done_d  = 1'b0;
    err_d   = err_q;
    we_d    = 1'b0;
    mem_we  = 1'b0;
    mem_idx = host_idx;
    mem_wd  = hbus.host_wdata;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          a_d     = cfg_addr_A;
          b_d     = cfg_addr_B;
          c_d     = cfg_addr_C;
          n_d     = cfg_n;
          state_d = LAUNCH;
        end else if (hbus.host_req) begin
          ack_d = 1'b1;
          if (!host_ok) err_d = 1'b1;
          if (hbus.host_we) mem_we = host_ok;
          else rdata_d = host_ok ? mem[host_idx] : '0;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        we_d    = acc_we;
        mem_idx = acc_idx;
        mem_wd  = acc_wdata;
        mem_we  = acc_we && acc_ok;
        if (!acc_ok) err_d = 1'b1;
        // falling edge of the controller's write strobe ends write-back
        if ((we_q && !acc_we) || tmo_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  assign hbus.host_rdata = rdata_q;
  assign hbus.host_ack   = ack_q;
  assign new_data = (state_q == LAUNCH);
  assign busy     = (state_q != IDLE);
  assign addr_A   = a_q;
  assign addr_B   = b_q;
  assign addr_C   = c_q;
  assign n        = n_q;
  assign done     = done_q;
  assign addr_err = err_q;
endmodule
